posit_encode: RTL and testbench
===============================

Name: posit_encode

Overview:
- Pipelined posit<16,1> encoder: packs a decoded value (sign, scale, fraction) into a 16-bit posit word.
- Rounds to nearest even and saturates to maxpos/minpos.
- Sits at the output side of the posit multiplier datapath, converting the wide product back to the 16-bit storage format.
- Uses a valid/ready handshake on both sides, with backpressure.

Parameters:
- N, 16, posit word width.
- ES, 1, exponent field width (useed = 4).
- SW, 8, width of the signed scale input (two's complement).
- FW, 28, fraction input width (hidden bit excluded, MSB-aligned).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  encoder can accept input this cycle.
- in_sign  input  1  sign of value (1 = negative).
- in_zero  input  1  value is exactly zero; overrides the other fields.
- in_nar  input  1  value is NaR; overrides everything, including in_zero.
- in_scale  input  SW  signed power of two: value = 2^scale * 1.frac.
- in_frac  input  FW  fraction bits below the hidden 1.
- out_valid  output  1  posit_out holds a result.
- out_ready  input  1  consumer accepts the result.
- posit_out  output  N  encoded posit.

Behaviour:
- Reset:
  - Synchronous active-high reset on rst, clocked by clk (one clock domain).
  - Clears both stage valids: out_valid=0, posit_out=16'h0000.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards in-flight data; nothing is emitted.
- Pipeline: 2 stages, advance = !out_valid || out_ready; in_ready = advance (combinational).
  - Accept on in_valid && in_ready.
  - Result appears on out_valid exactly 2 cycles after acceptance when there is no stall.
  - Throughput: 1 per cycle.
- Stall: while out_valid && !out_ready, both stages hold, posit_out is stable, in_ready=0.
  - No data loss or duplication.
  - Bubbles (stage valid=0) propagate normally.
- Stage 1 (pack):
  - k = in_scale >>> ES (arithmetic); e = in_scale[ES-1:0].
  - Regime: k>=0 gives k+1 ones then a zero; k<0 gives -k zeros then a one.
  - Body = regime, e, in_frac, right-shifted into an (N-1)-bit field plus guard bit and sticky OR of all discarded bits.
  - Special flags pass through alongside.
- Stage 2 (round/sign):
  - Round to nearest, ties to even: increment when guard && (sticky || lsb).
  - A carry out of the fraction propagates into exponent/regime by plain integer add.
  - Clamp: a magnitude above 15'h7FFF becomes 15'h7FFF; a nonzero value rounding to 0 becomes 15'h0001.
  - Negative: posit_out = two's complement of {0, magnitude}.
- Saturation:
  - scale > (N-2)*2^ES (=28) gives maxpos 16'h7FFF, or 16'h8001 if negative.
  - scale < -28 gives minpos 16'h0001, or 16'hFFFF if negative.
  - The result never becomes NaR or zero from a finite nonzero input.
- Specials:
  - in_nar gives 16'h8000.
  - in_zero (with in_nar=0) gives 16'h0000, regardless of sign, scale and frac.
- Fields are ignored when in_valid=0 or in_ready=0.

Test Plan:
- Reset with rst=1 for 2 cycles, then release, idle -> out_valid=0, posit_out=16'h0000, in_ready=1.
- Basic values, back-to-back, out_ready=1:
  - scale=0, frac=0 -> 16'h4000.
  - scale=0, frac=28'h8000000 -> 16'h4800.
  - sign=1, scale=0, frac=0 -> 16'hC000.
  - scale=2, frac=0 -> 16'h6000.
  - Each result appears 2 cycles after its input, one per cycle, in order.
- Rounding, scale=0:
  - frac=28'h0008000 (tie, lsb 0) -> 16'h4000.
  - frac=28'h0018000 (tie, lsb 1) -> 16'h4002.
  - frac=28'hFFF8000 (carry) -> 16'h5000.
- Saturation and specials:
  - scale=29 -> 16'h7FFF.
  - scale=-40 -> 16'h0001.
  - sign=1, scale=-40 -> 16'hFFFF.
  - in_zero -> 16'h0000.
  - in_nar with in_zero=1 -> 16'h8000.
- Backpressure: stream 4 inputs, hold out_ready=0 for 3 cycles after the first output -> posit_out stable, in_ready=0 during the stall; all 4 results delivered once each, in order.
- Reset mid-stream: assert rst with 2 results in flight -> no out_valid afterwards; the next input after release is encoded correctly with 2-cycle latency.

Source files
------------

// File: rtl/posit_encode.sv
// Two-stage posit<N,ES> encoder: packs sign/scale/fraction into a posit word with
// round-to-nearest-even and saturation to maxpos/minpos. Valid/ready on both sides.
module posit_encode #(
    parameter int unsigned N  = 16,
    parameter int unsigned ES = 1,
    parameter int unsigned SW = 8,
    parameter int unsigned FW = 28
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic          in_zero,
    input  logic          in_nar,
    input  logic [SW-1:0] in_scale,
    input  logic [FW-1:0] in_frac,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  posit_out
);

    // Regime lead bit, terminator, exponent, fraction, plus room for the largest shift.
    localparam int unsigned VW = 2 + ES + FW + N - 1;
    localparam logic signed [SW-1:0] ScaleMax = SW'((N - 2) << ES);

    logic advance;

    logic          s1_valid_q;
    logic [N-2:0]  s1_body_q;
    logic          s1_guard_q;
    logic          s1_sticky_q;
    logic          s1_sign_q;
    logic          s1_zero_q;
    logic          s1_nar_q;

    logic          out_valid_q;
    logic [N-1:0]  posit_q;

    logic signed [SW-1:0] k;
    logic [SW-1:0]        sh;
    logic signed [VW-1:0] v;
    logic signed [VW-1:0] sv;
    logic [N-2:0]         body_d;
    logic                 guard_d;
    logic                 sticky_d;

    logic                 inc;
    logic [N-1:0]         mag;
    logic [N-1:0]         posit_d;

    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign posit_out = posit_q;

    // Stage 1: an arithmetic shift of {lead, ~lead, e, frac} replicates the lead bit,
    // giving k+1 ones (k>=0) or -k zeros (k<0) ahead of the regime terminator.
    always_comb begin
        k        = $signed(in_scale) >>> ES;
        sh       = k[SW-1] ? ~k : k;
        v        = {~k[SW-1], k[SW-1], in_scale[ES-1:0], in_frac, {(N-1){1'b0}}};
        sv       = v >>> sh;
        body_d   = sv[VW-1 -: N-1];
        guard_d  = sv[VW-N];
        sticky_d = |sv[VW-N-1:0];
        if ($signed(in_scale) > ScaleMax) begin
            body_d   = '1;
            guard_d  = 1'b0;
            sticky_d = 1'b0;
        end else if ($signed(in_scale) < -ScaleMax) begin
            body_d   = {{(N-2){1'b0}}, 1'b1};
            guard_d  = 1'b0;
            sticky_d = 1'b0;
        end
    end

    // Stage 2: round, clamp away from NaR and zero, apply sign, then specials.
    always_comb begin
        inc = s1_guard_q & (s1_sticky_q | s1_body_q[0]);
        mag = {1'b0, s1_body_q} + {{(N-1){1'b0}}, inc};
        if (mag[N-1]) begin
            mag = {1'b0, {(N-1){1'b1}}};
        end else if (mag == '0) begin
            mag = {{(N-1){1'b0}}, 1'b1};
        end
        posit_d = s1_sign_q ? -mag : mag;
        if (s1_nar_q) begin
            posit_d = {1'b1, {(N-1){1'b0}}};
        end else if (s1_zero_q) begin
            posit_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_body_q   <= '0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_nar_q    <= 1'b0;
            out_valid_q <= 1'b0;
            posit_q     <= '0;
        end else if (advance) begin
            s1_valid_q  <= in_valid;
            s1_body_q   <= body_d;
            s1_guard_q  <= guard_d;
            s1_sticky_q <= sticky_d;
            s1_sign_q   <= in_sign;
            s1_zero_q   <= in_zero;
            s1_nar_q    <= in_nar;
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                posit_q <= posit_d;
            end
        end
    end

endmodule

// File: tb/tb_posit_encode.sv
// Directed bench for posit_encode: hand-computed vectors, a FIFO of expected words,
// stall and mid-stream reset scenarios.
module tb_posit_encode;

    typedef struct packed {
        logic        sign;
        logic        zero;
        logic        nar;
        logic [7:0]  scale;
        logic [27:0] frac;
        logic [15:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sign = 1'b0;
    logic        in_zero = 1'b0;
    logic        in_nar = 1'b0;
    logic [7:0]  in_scale = '0;
    logic [27:0] in_frac = '0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] posit_out;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   chk_lat = 1'b1;
    vec_t vt[18];

    logic [15:0] exp_q[$];
    int          cyc_q[$];
    int          id_q[$];
    logic [15:0] want;
    int          c0;
    int          id;

    posit_encode dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_zero   (in_zero),
        .in_nar    (in_nar),
        .in_scale  (in_scale),
        .in_frac   (in_frac),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .posit_out (posit_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic z, input logic n,
                                input logic [7:0] sc, input logic [27:0] f,
                                input logic [15:0] e);
        vec_t r;
        r.sign  = s;
        r.zero  = z;
        r.nar   = n;
        r.scale = sc;
        r.frac  = f;
        r.exp   = e;
        return r;
    endfunction

    // Output monitor: pops the expected FIFO on each handshake, checks holds during stalls.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    want = exp_q.pop_front();
                    c0   = cyc_q.pop_front();
                    id   = id_q.pop_front();
                    check($sformatf("data_v%0d", id), 32'(posit_out), 32'(want));
                    if (chk_lat) check($sformatf("latency_v%0d", id), cyc - c0, 32'd2);
                end
            end else if (out_valid) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                if (exp_q.size() != 0) check("stall_data", 32'(posit_out), 32'(exp_q[0]));
            end
        end
    end

    // Drives vectors lo..hi back to back; called and returns at posedge+1.
    task automatic send_list(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            int w;
            w        = 0;
            in_valid = 1'b1;
            in_sign  = vt[i].sign;
            in_zero  = vt[i].zero;
            in_nar   = vt[i].nar;
            in_scale = vt[i].scale;
            in_frac  = vt[i].frac;
            @(negedge clk);
            while (!in_ready && w < 50) begin
                w++;
                @(negedge clk);
            end
            if (!in_ready) begin
                check($sformatf("accept_timeout_v%0d", i), 32'd0, 32'd1);
            end else begin
                exp_q.push_back(vt[i].exp);
                cyc_q.push_back(cyc);
                id_q.push_back(i);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_frac  = 28'hA5A5A5A;
        in_scale = 8'h55;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 40) begin
            w++;
            @(negedge clk);
        end
        check("drain_left", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = mk(1'b0, 1'b0, 1'b0, 8'd0,  28'h0000000, 16'h4000);
        vt[1]  = mk(1'b0, 1'b0, 1'b0, 8'd0,  28'h8000000, 16'h4800);
        vt[2]  = mk(1'b1, 1'b0, 1'b0, 8'd0,  28'h0000000, 16'hC000);
        vt[3]  = mk(1'b0, 1'b0, 1'b0, 8'd2,  28'h0000000, 16'h6000);
        vt[4]  = mk(1'b0, 1'b0, 1'b0, 8'd0,  28'h0008000, 16'h4000);
        vt[5]  = mk(1'b0, 1'b0, 1'b0, 8'd0,  28'h0018000, 16'h4002);
        vt[6]  = mk(1'b0, 1'b0, 1'b0, 8'd0,  28'hFFF8000, 16'h5000);
        vt[7]  = mk(1'b0, 1'b0, 1'b0, 8'h1D, 28'h0000000, 16'h7FFF);
        vt[8]  = mk(1'b0, 1'b0, 1'b0, 8'hD8, 28'h0000000, 16'h0001);
        vt[9]  = mk(1'b1, 1'b0, 1'b0, 8'hD8, 28'h0000000, 16'hFFFF);
        vt[10] = mk(1'b1, 1'b1, 1'b0, 8'd5,  28'h1234567, 16'h0000);
        vt[11] = mk(1'b0, 1'b1, 1'b1, 8'd0,  28'h0000000, 16'h8000);
        vt[12] = mk(1'b0, 1'b0, 1'b0, 8'hE5, 28'h0000001, 16'h0002);
        vt[13] = mk(1'b0, 1'b0, 1'b0, 8'd1,  28'h0000000, 16'h5000);
        vt[14] = mk(1'b0, 1'b0, 1'b0, 8'hFF, 28'h0000000, 16'h3000);
        vt[15] = mk(1'b1, 1'b0, 1'b0, 8'd3,  28'h4000000, 16'h9600);
        vt[16] = mk(1'b0, 1'b0, 1'b0, 8'h1C, 28'h0000000, 16'h7FFF);
        vt[17] = mk(1'b0, 1'b0, 1'b0, 8'hE4, 28'h0000000, 16'h0001);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_posit_out", 32'(posit_out), 32'h0000);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        send_list(0, 3);
        wait_drain();
        send_list(4, 6);
        wait_drain();
        send_list(7, 13);
        wait_drain();

        // Backpressure: stall the consumer for 3 cycles after the first result.
        chk_lat = 1'b0;
        fork
            send_list(14, 17);
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (!out_valid && w < 20) begin
                    w++;
                    @(negedge clk);
                end
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        chk_lat = 1'b1;

        // Reset with one result stalled at the output and one in stage 1.
        out_ready = 1'b0;
        send_list(0, 1);
        rst = 1'b1;
        exp_q.delete();
        cyc_q.delete();
        id_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("flush_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send_list(13, 13);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
